// File: rtl/tdm_demux_1_to_4.sv
// tdm_demux_1_to_4
// Receive end of a 4-channel time-division link. A single serial lane plus a
// frame-sync marker is tracked slot by slot; each slot's word is steered into
// one of four registered channel outputs with per-channel valid strobes,
// a frame-complete pulse, a sync-error pulse and lock tracking.
//
// Build option: define TDM_PARITY_EN to add a fifth slot per frame that
// carries even parity (bitwise XOR of the four channel words). Without it the
// frame is four slots long and parity_err never asserts.
module tdm_demux_1_to_4 #(
  parameter int DATA_W     = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] Y0,
  output logic [DATA_W-1:0] Y1,
  output logic [DATA_W-1:0] Y2,
  output logic [DATA_W-1:0] Y3,
  output logic [3:0]        ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              parity_err,
  output logic              locked
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_W    = 3;
  localparam int LAST_SLOT = 4;
`else
  localparam int SLOT_W    = 2;
  localparam int LAST_SLOT = 3;
`endif

  localparam logic [SLOT_W-1:0] SLOT_0    = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_1    = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_2    = SLOT_W'(2);
  localparam logic [SLOT_W-1:0] SLOT_3    = SLOT_W'(3);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LAST_SLOT);
  localparam logic [4:0]        MISS_LIM  = 5'(MISS_LIMIT);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic [3:0]        miss_cnt;
  logic [3:0]        miss_nxt;

  logic [DATA_W-1:0] y0_nxt;
  logic [DATA_W-1:0] y1_nxt;
  logic [DATA_W-1:0] y2_nxt;
  logic [DATA_W-1:0] y3_nxt;
  logic [3:0]        valid_nxt;
  logic              done_nxt;
  logic              serr_nxt;
  logic              perr_nxt;

  // Slot after s, wrapping from the last slot of the frame back to slot 0.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    if (s >= SLOT_LAST) begin
      next_slot = SLOT_0;
    end else begin
      next_slot = s + SLOT_W'(1);
    end
  endfunction

  // True when one more missed frame_sync at slot 0 exhausts the miss budget.
  function automatic logic miss_limit_hit(input logic [3:0] m);
    miss_limit_hit = ({1'b0, m} + 5'd1) >= MISS_LIM;
  endfunction

`ifdef TDM_PARITY_EN
  // Even parity over the four channel words captured this frame.
  function automatic logic [DATA_W-1:0] parity_of(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] d
  );
    parity_of = a ^ b ^ c ^ d;
  endfunction
`endif

  // Slot tracking and lock FSM: decide the next state, slot, miss count and
  // the values the registered outputs take after this edge.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    miss_nxt  = miss_cnt;
    y0_nxt    = Y0;
    y1_nxt    = Y1;
    y2_nxt    = Y2;
    y3_nxt    = Y3;
    valid_nxt = 4'b0000;
    done_nxt  = 1'b0;
    serr_nxt  = 1'b0;
    perr_nxt  = 1'b0;

    if (en) begin
      case (state)
        HUNT: begin
          // Only a frame_sync can start a frame; lane data is ignored.
          if (frame_sync) begin
            y0_nxt    = din;
            valid_nxt = 4'b0001;
            slot_nxt  = SLOT_1;
            miss_nxt  = 4'd0;
            state_nxt = LOCKED;
          end
        end

        LOCKED: begin
          if (frame_sync && (slot != SLOT_0)) begin
            // Marker in the wrong place: drop the partial frame and treat
            // this slot as slot 0 of a new frame.
            serr_nxt  = 1'b1;
            y0_nxt    = din;
            valid_nxt = 4'b0001;
            slot_nxt  = SLOT_1;
            miss_nxt  = 4'd0;
          end else if ((slot == SLOT_0) && !frame_sync && miss_limit_hit(miss_cnt)) begin
            // Too many frames without a marker: give up and hunt again.
            state_nxt = HUNT;
            slot_nxt  = SLOT_0;
            miss_nxt  = 4'd0;
          end else begin
            if (slot == SLOT_0) begin
              miss_nxt = frame_sync ? 4'd0 : (miss_cnt + 4'd1);
            end
            if (slot == SLOT_0) begin
              y0_nxt    = din;
              valid_nxt = 4'b0001;
            end
            if (slot == SLOT_1) begin
              y1_nxt    = din;
              valid_nxt = 4'b0010;
            end
            if (slot == SLOT_2) begin
              y2_nxt    = din;
              valid_nxt = 4'b0100;
            end
            if (slot == SLOT_3) begin
              y3_nxt    = din;
              valid_nxt = 4'b1000;
            end
            if (slot == SLOT_LAST) begin
              done_nxt = 1'b1;
`ifdef TDM_PARITY_EN
              // The parity slot writes no channel; it only checks the frame.
              perr_nxt = (din != parity_of(Y0, Y1, Y2, Y3));
`endif
            end
            slot_nxt = next_slot(slot);
          end
        end

        default: begin
          state_nxt = HUNT;
          slot_nxt  = SLOT_0;
          miss_nxt  = 4'd0;
        end
      endcase
    end
  end

  // State register: lock state, slot position and missed-sync count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      slot     <= SLOT_0;
      miss_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  // Output registers: channel words, one-cycle strobes and the lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y0         <= '0;
      Y1         <= '0;
      Y2         <= '0;
      Y3         <= '0;
      ch_valid   <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      parity_err <= 1'b0;
      locked     <= 1'b0;
    end else begin
      Y0         <= y0_nxt;
      Y1         <= y1_nxt;
      Y2         <= y2_nxt;
      Y3         <= y3_nxt;
      ch_valid   <= valid_nxt;
      frame_done <= done_nxt;
      sync_err   <= serr_nxt;
      parity_err <= perr_nxt;
      locked     <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Self-checking bench for tdm_demux_1_to_4: directed scenarios with fixed
// expectations, then randomized traffic compared against a frame-level model.
module tb_tdm_demux_1_to_4;
  localparam int DW = 1;
  localparam int ML = 2;
`ifdef TDM_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] Y0, Y1, Y2, Y3;
  logic [3:0]    ch_valid;
  logic          frame_done, sync_err, parity_err, locked;

  int checks = 0;
  int errors = 0;

  // Reference model state: lock flag, position in frame, missed-sync count,
  // captured words and the strobes expected after the latest edge.
  bit            m_locked;
  int            m_pos;
  int            m_miss;
  logic [DW-1:0] m_y [4];
  logic [3:0]    e_valid;
  bit            e_done, e_serr, e_perr;

  tdm_demux_1_to_4 #(.DATA_W(DW), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .frame_sync(frame_sync),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .ch_valid(ch_valid),
    .frame_done(frame_done), .sync_err(sync_err), .parity_err(parity_err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input bit r, input bit e, input logic [DW-1:0] d, input bit fs);
    e_valid = 4'b0000; e_done = 0; e_serr = 0; e_perr = 0;
    if (r) begin
      m_locked = 0; m_pos = 0; m_miss = 0;
      for (int i = 0; i < 4; i++) m_y[i] = '0;
    end else if (e) begin
      if (!m_locked) begin
        if (fs) begin
          m_y[0] = d; e_valid = 4'b0001; m_pos = 1; m_locked = 1; m_miss = 0;
        end
      end else if (fs && m_pos != 0) begin
        e_serr = 1; m_y[0] = d; e_valid = 4'b0001; m_pos = 1; m_miss = 0;
      end else if (m_pos == 0 && !fs && m_miss + 1 >= ML) begin
        m_locked = 0; m_pos = 0; m_miss = 0;
      end else begin
        if (m_pos == 0) m_miss = fs ? 0 : m_miss + 1;
        if (m_pos < 4) begin
          m_y[m_pos] = d;
          e_valid = 4'(1 << m_pos);
        end else begin
          e_perr = (d != (m_y[0] ^ m_y[1] ^ m_y[2] ^ m_y[3]));
        end
        if (m_pos == FRAME_LEN - 1) e_done = 1;
        m_pos = (m_pos + 1) % FRAME_LEN;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic cycle(input bit r, input bit e, input logic [DW-1:0] d, input bit fs);
    rst = r; en = e; din = d; frame_sync = fs;
    @(posedge clk);
    #1;
    model_step(r, e, d, fs);
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 1);
    checks++;
    if ({Y3, Y2, Y1, Y0, ch_valid, frame_done, sync_err, parity_err, locked} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {Y3, Y2, Y1, Y0, ch_valid, frame_done, sync_err, parity_err, locked});
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({ch_valid, locked, Y0} !== 6'b0) begin
      errors++;
      $display("FAIL hunt_ignores_din got %b exp 000000", {ch_valid, locked, Y0});
    end
  endtask

  task automatic test_lock_capture();
    logic [3:0] pat;
    logic [5:0] exp_v;
    pat = 4'b1101;
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, pat[k], k == 0);
      exp_v = {4'(1 << k), (k == 3 && FRAME_LEN == 4), 1'b1};
      checks++;
      if ({ch_valid, frame_done, locked} !== exp_v) begin
        errors++;
        $display("FAIL lock_slot%0d got %b exp %b", k, {ch_valid, frame_done, locked}, exp_v);
      end
    end
    checks++;
    if ({Y3, Y2, Y1, Y0} !== 4'b1101) begin
      errors++;
      $display("FAIL lock_y got %b exp 1101", {Y3, Y2, Y1, Y0});
    end
`ifdef TDM_PARITY_EN
    cycle(0, 1, 1, 0);
    checks++;
    if ({ch_valid, frame_done, parity_err} !== 6'b000010) begin
      errors++;
      $display("FAIL lock_parity_slot got %b exp 000010", {ch_valid, frame_done, parity_err});
    end
`endif
  endtask

  task automatic test_en_gaps();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 0, 0);
    for (int g = 0; g < 2; g++) begin
      cycle(0, 0, 1, 1);
      checks++;
      if ({ch_valid, frame_done, sync_err, locked, Y1, Y0} !== 9'b000000101) begin
        errors++;
        $display("FAIL gap%0d got %b exp 000000101", g, {ch_valid, frame_done, sync_err, locked, Y1, Y0});
      end
    end
    cycle(0, 1, 1, 0);
    checks++;
    if (ch_valid !== 4'b0100) begin
      errors++;
      $display("FAIL gap_resume got %b exp 0100", ch_valid);
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({Y3, Y2, Y1, Y0, ch_valid, frame_done} !== {4'b1101, 4'b1000, FRAME_LEN == 4}) begin
      errors++;
      $display("FAIL gap_final got %b exp %b", {Y3, Y2, Y1, Y0, ch_valid, frame_done}, {4'b1101, 4'b1000, FRAME_LEN == 4});
    end
  endtask

  task automatic test_misaligned_sync();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 1);
    checks++;
    if ({sync_err, Y0, ch_valid, frame_done, locked} !== 8'b10000101) begin
      errors++;
      $display("FAIL misalign got %b exp 10000101", {sync_err, Y0, ch_valid, frame_done, locked});
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({sync_err, ch_valid, Y1} !== 6'b000101) begin
      errors++;
      $display("FAIL misalign_next got %b exp 000101", {sync_err, ch_valid, Y1});
    end
  endtask

  task automatic test_lock_loss();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    if (FRAME_LEN == 5) cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    checks++;
    if ({ch_valid, Y0, locked} !== 6'b000101) begin
      errors++;
      $display("FAIL loss_first_miss got %b exp 000101", {ch_valid, Y0, locked});
    end
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    if (FRAME_LEN == 5) cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    checks++;
    if ({ch_valid, frame_done, Y0, locked} !== 7'b0000000) begin
      errors++;
      $display("FAIL loss_drop got %b exp 0000000", {ch_valid, frame_done, Y0, locked});
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({ch_valid, Y0, locked} !== 6'b000000) begin
      errors++;
      $display("FAIL loss_hunt got %b exp 000000", {ch_valid, Y0, locked});
    end
    cycle(0, 1, 1, 1);
    checks++;
    if ({ch_valid, Y0, locked} !== 6'b000111) begin
      errors++;
      $display("FAIL loss_relock got %b exp 000111", {ch_valid, Y0, locked});
    end
  endtask

  task automatic test_reset_mid_frame();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 0);
    checks++;
    if ({Y3, Y2, Y1, Y0, ch_valid, frame_done, sync_err, parity_err, locked} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs got %b exp 0", {Y3, Y2, Y1, Y0, ch_valid, frame_done, sync_err, parity_err, locked});
    end
    cycle(0, 1, 1, 0);
    checks++;
    if ({ch_valid, locked} !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_needs_sync got %b exp 00000", {ch_valid, locked});
    end
    cycle(0, 1, 1, 1);
    checks++;
    if ({ch_valid, locked} !== 5'b00011) begin
      errors++;
      $display("FAIL midrst_relock got %b exp 00011", {ch_valid, locked});
    end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    logic [3:0] pat;
    pat = 4'b1101;
    cycle(1, 0, 0, 0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 4; k++) cycle(0, 1, pat[k], k == 0);
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL parity_slot3_done got %b exp 0", frame_done);
      end
      cycle(0, 1, (rep == 0) ? 1'b1 : 1'b0, 0);
      checks++;
      if ({frame_done, parity_err, ch_valid} !== {1'b1, rep == 1, 4'b0000}) begin
        errors++;
        $display("FAIL parity_rep%0d got %b exp %b", rep, {frame_done, parity_err, ch_valid}, {1'b1, rep == 1, 4'b0000});
      end
    end
  endtask
`endif

  task automatic test_random();
    bit r, e, fs;
    logic [DW-1:0] d;
    logic [4*DW+7:0] got, exp_v;
    cycle(1, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (!m_locked) fs = ($urandom_range(0, 4) == 0);
      else if (m_pos == 0) fs = ($urandom_range(0, 9) < 7);
      else fs = ($urandom_range(0, 24) == 0);
      d = DW'($urandom);
      cycle(r, e, d, fs);
      got   = {Y3, Y2, Y1, Y0, ch_valid, frame_done, sync_err, parity_err, locked};
      exp_v = {m_y[3], m_y[2], m_y[1], m_y[0], e_valid, e_done, e_serr, e_perr, m_locked};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d got %b exp %b", n, got, exp_v);
      end
      checks++;
      if ($countones(ch_valid) > 1) begin
        errors++;
        $display("FAIL random_onehot%0d got %b exp at most one bit", n, ch_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_capture();
    test_en_gaps();
    test_misaligned_sync();
    test_lock_loss();
    test_reset_mid_frame();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
